// File: rtl/inst_fetch_requester_pkg.sv
// Shared widths, FSM encoding and small helpers for the instruction-fetch requester.
package inst_fetch_requester_pkg;

    localparam int FETCH_IW     = 16;
    localparam int FETCH_CW     = 4;
    localparam int FETCH_WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } fetch_state_t;

    function automatic logic fetch_active(input fetch_state_t s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage

// File: rtl/inst_fetch_requester_fifo.sv
// Flop-array FIFO for fetched {instruction, counter} words; pointers carry a wrap bit.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;

    // Storage and pointer update; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign count = wr_ptr_r - rd_ptr_r;
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/inst_fetch_requester.sv
// Instruction-fetch requester: token-driven fetch FSM, end-of-program detection and output FIFO.
module inst_fetch_requester
    import inst_fetch_requester_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int RSP_WAIT = 2,
    parameter int IW       = FETCH_IW,
    parameter int CW       = FETCH_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [CW-1:0] req_token,
    input  logic [IW-1:0] rsp_inst,
    input  logic [CW-1:0] rsp_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_inst,
    output logic [CW-1:0] out_pc,
    output logic          busy,
    output logic          prog_end
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]             DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]           CW_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FETCH_WAIT_W-1:0] WAIT_LOAD = FETCH_WAIT_W'(RSP_WAIT - 1);
    localparam logic [FETCH_WAIT_W-1:0] WAIT_ONE  = {{(FETCH_WAIT_W-1){1'b0}}, 1'b1};

    fetch_state_t              state_r, state_s;
    logic [CW-1:0]             token_r;
    logic [CW-1:0]             base_r;
    logic [FETCH_WAIT_W-1:0]   wait_r;
    logic                      prog_end_r;
    logic                      busy_r;
    logic [AW:0]               count_s;
    logic [IW+CW-1:0]          head_s;
    logic                      slot_free_s, advanced_s;
    logic                      issue_s, push_s, capture_s, end_s, pop_s;

    // The in-flight request already counts as occupancy once pushed, so ISSUE only needs one free slot.
    assign slot_free_s = (count_s < DEPTH_C);
    assign advanced_s  = (rsp_count == (base_r + CW_ONE));
    assign pop_s       = out_valid && out_ready;

    // Next-state and per-cycle action decode.
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        push_s    = 1'b0;
        capture_s = 1'b0;
        end_s     = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    capture_s = 1'b1;
                    state_s   = S_ISSUE;
                end else begin
                    state_s   = state_r;
                end
            end
            S_ISSUE, S_HOLD: begin
                if (slot_free_s) begin
                    issue_s = 1'b1;
                    state_s = S_WAIT;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_WAIT: begin
                if (wait_r == '0) begin
                    state_s = S_CHECK;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_CHECK: begin
                if (advanced_s) begin
                    push_s  = 1'b1;
                    state_s = S_ISSUE;
                end else begin
                    end_s   = 1'b1;
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM, token, response-wait counter, baseline and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            token_r    <= '0;
            base_r     <= '0;
            wait_r     <= '0;
            prog_end_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= fetch_active(state_s);
            if (issue_s) begin
                token_r <= token_r + CW_ONE;
                wait_r  <= WAIT_LOAD;
            end else if ((state_r == S_WAIT) && (wait_r != '0)) begin
                wait_r  <= wait_r - WAIT_ONE;
            end
            if (capture_s || push_s) begin
                base_r <= rsp_count;
            end
            if (capture_s) begin
                prog_end_r <= 1'b0;
            end else if (end_s) begin
                prog_end_r <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (IW + CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   ({rsp_inst, rsp_count}),
        .pop   (pop_s),
        .dout  (head_s),
        .count (count_s)
    );

    assign req_token = token_r;
    assign busy      = busy_r;
    assign prog_end  = prog_end_r;
    assign out_valid = (count_s != '0);
    assign out_inst  = head_s[IW+CW-1:CW];
    assign out_pc    = head_s[CW-1:0];

endmodule

// File: tb/tb_inst_fetch_requester.sv
// Scoreboard bench for inst_fetch_requester with a behavioural fetch responder.
module tb_inst_fetch_requester;
    import inst_fetch_requester_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  req_token;
    logic [15:0] rsp_inst;
    logic [3:0]  rsp_count;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [3:0]  out_pc;
    logic        busy;
    logic        prog_end;

    always #5 clk = ~clk;

    inst_fetch_requester dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req_token (req_token),
        .rsp_inst  (rsp_inst),
        .rsp_count (rsp_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .busy      (busy),
        .prog_end  (prog_end)
    );

    // Responder: one instruction per token change while the program lasts.
    logic [15:0] prog_mem [16];
    int          prog_len = 0;
    logic [3:0]  load_val = 4'd0;
    bit          load_req = 1'b0;
    bit          load_ack = 1'b0;
    int          idx;
    logic [3:0]  last_tok;

    always @(posedge clk) begin
        if (load_req != load_ack) begin
            load_ack  <= load_req;
            rsp_count <= load_val;
            rsp_inst  <= 16'h0000;
            idx       <= 0;
        end else if (rst_n === 1'b1 && req_token != last_tok && idx < prog_len) begin
            rsp_count <= rsp_count + 4'd1;
            rsp_inst  <= prog_mem[idx];
            idx       <= idx + 1;
        end
        last_tok <= req_token;
    end

    // Ready driver: manual level, or pop only in CHECK cycles once three words are held.
    bit auto_ready = 1'b0;
    bit man_ready  = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = auto_ready ? ((dut.state_r == S_CHECK) && (dut.count_s == 3'd3)) : man_ready;
    end

    // Scoreboard state and check queues.
    logic [19:0] exp_q [$];
    string       cn_q [$];
    logic [31:0] ca_q [$];
    logic [31:0] ce_q [$];
    int          checks   = 0;
    int          failures = 0;
    string       m_n;
    logic [31:0] m_a, m_e;
    logic [19:0] m_x;

    // Monitor: settles posted checks and compares every handshake against the expected queue.
    always @(negedge clk) begin
        while (cn_q.size() > 0) begin
            m_n = cn_q.pop_front();
            m_a = ca_q.pop_front();
            m_e = ce_q.pop_front();
            checks++;
            if (m_a !== m_e) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", m_n, m_a, m_e);
            end
        end
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop: got %0h expected none", {out_inst, out_pc});
            end else begin
                m_x = exp_q.pop_front();
                if ({out_inst, out_pc} !== m_x) begin
                    failures++;
                    $display("FAIL pop_word: got %0h expected %0h", {out_inst, out_pc}, m_x);
                end
            end
        end
    end

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        cn_q.push_back(n);
        ca_q.push_back(a);
        ce_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic load(input int n, input logic [3:0] base);
        prog_len = n;
        load_val = base;
        load_req = ~load_req;
        cyc(2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_state(input fetch_state_t s, input int budget, input string nm);
        int n = 0;
        while (dut.state_r != s && n < budget) begin
            cyc(1);
            n++;
        end
        post({nm, "_timeout"}, {31'd0, dut.state_r == s}, 32'd1);
    endtask

    task automatic wait_prog_end(input int budget, input string nm);
        int n = 0;
        while (prog_end !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        post({nm, "_prog_end"}, {31'd0, prog_end}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        load_req  = 1'b1;
        cyc(2);
        post("rst_token", 32'(req_token), 32'd0);
        post("rst_valid", 32'(out_valid), 32'd0);
        post("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        cyc(1);

        // 1: reset in the middle of WAIT
        man_ready = 1'b1;
        pulse_start();
        wait_state(S_WAIT, 20, "t1_wait");
        rst_n = 1'b0;
        #1;
        post("t1_token", 32'(req_token), 32'd0);
        post("t1_valid", 32'(out_valid), 32'd0);
        post("t1_inst",  32'(out_inst),  32'd0);
        post("t1_pc",    32'(out_pc),    32'd0);
        post("t1_busy",  32'(busy),      32'd0);
        post("t1_pend",  32'(prog_end),  32'd0);
        post("t1_state", 32'(dut.state_r), 32'(S_IDLE));
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        post("t1_token_idle", 32'(req_token), 32'd0);

        // 2: basic three-instruction program
        reset_dut();
        prog_mem[0] = 16'h1234; prog_mem[1] = 16'h5678; prog_mem[2] = 16'h9ABC;
        load(3, 4'd0);
        exp_q.push_back({16'h1234, 4'd1});
        exp_q.push_back({16'h5678, 4'd2});
        exp_q.push_back({16'h9ABC, 4'd3});
        pulse_start();
        wait_prog_end(100, "t2");
        post("t2_busy",  32'(busy),      32'd0);
        post("t2_token", 32'(req_token), 32'd4);
        cyc(3);
        post("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3: backpressure fills the FIFO and parks the FSM in HOLD
        reset_dut();
        man_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prog_mem[i] = 16'h1111 * 16'(i + 1);
            exp_q.push_back({16'h1111 * 16'(i + 1), 4'(i + 1)});
        end
        load(8, 4'd0);
        pulse_start();
        wait_state(S_HOLD, 100, "t3_hold");
        post("t3_count", 32'(dut.count_s), 32'd4);
        post("t3_token", 32'(req_token),   32'd4);
        post("t3_head",  32'({out_valid, out_inst, out_pc}), 32'({1'b1, 16'h1111, 4'd1}));
        cyc(10);
        post("t3_still_hold", 32'(dut.state_r), 32'(S_HOLD));
        post("t3_count_held", 32'(dut.count_s), 32'd4);
        man_ready = 1'b1;
        wait_prog_end(200, "t3");
        post("t3_token_end", 32'(req_token), 32'd9);
        cyc(6);
        post("t3_drained", 32'(exp_q.size()), 32'd0);
        post("t3_valid",   32'(out_valid),    32'd0);

        // 4: counter wrap 14 -> 15 -> 0 -> 1
        reset_dut();
        prog_mem[0] = 16'hCAFE; prog_mem[1] = 16'hBEEF; prog_mem[2] = 16'hF00D;
        load(3, 4'd14);
        exp_q.push_back({16'hCAFE, 4'd15});
        exp_q.push_back({16'hBEEF, 4'd0});
        exp_q.push_back({16'hF00D, 4'd1});
        pulse_start();
        begin
            int n = 0;
            while (!(out_valid === 1'b1 && out_pc == 4'd0) && n < 60) begin
                @(negedge clk);
                n++;
            end
            post("t4_pc0_seen", {31'd0, out_valid === 1'b1 && out_pc == 4'd0}, 32'd1);
        end
        post("t4_no_early_end", 32'(prog_end), 32'd0);
        wait_prog_end(100, "t4");
        post("t4_token", 32'(req_token), 32'd4);
        cyc(4);
        post("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: push and pop in the same CHECK cycle keep occupancy constant
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            prog_mem[i] = 16'h5001 + 16'(i);
            exp_q.push_back({16'h5001 + 16'(i), 4'(i + 1)});
        end
        load(6, 4'd0);
        man_ready  = 1'b0;
        auto_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(dut.state_r == S_CHECK && dut.count_s == 3'd3) && n < 60);
            @(negedge clk);
            post("t5_occupancy", 32'(dut.count_s), 32'd3);
        end
        auto_ready = 1'b0;
        wait_prog_end(100, "t5");
        post("t5_count", 32'(dut.count_s), 32'd3);
        post("t5_head",  32'(out_pc),      32'd4);
        post("t5_token", 32'(req_token),   32'd7);

        // 6: restart from DONE appends behind the words still queued
        prog_mem[0] = 16'h7777; prog_mem[1] = 16'h8888;
        load(2, 4'd6);
        exp_q.push_back({16'h7777, 4'd7});
        exp_q.push_back({16'h8888, 4'd8});
        pulse_start();
        post("t6_pend_clear", 32'(prog_end), 32'd0);
        post("t6_busy",       32'(busy),     32'd1);
        wait_state(S_HOLD, 50, "t6_hold");
        post("t6_count", 32'(dut.count_s), 32'd4);
        man_ready = 1'b1;
        wait_prog_end(100, "t6");
        post("t6_token", 32'(req_token), 32'd10);
        cyc(8);
        post("t6_drained", 32'(exp_q.size()), 32'd0);
        post("t6_valid",   32'(out_valid),    32'd0);

        @(negedge clk);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
